ahb_uart_tx: RTL and testbench
==============================

AHB_UART_TX -- requirements
Module: ahb_uart_tx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DEFAULT_DIVISOR, default 16, meaning the reset value of the DIVISOR register.
REQ-003 The block SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nreset, input, 1, meaning reset; asynchronous assertion, active-low.
REQ-005 The block SHALL have port sel, input, 1, meaning device select from the bus decoder.
REQ-006 The block SHALL have port addr, input, 32, meaning the byte address; only bits [3:2] are decoded.
REQ-007 The block SHALL have port write, input, 1, meaning 1=write, 0=read.
REQ-008 The block SHALL have port trans, input, 2, meaning transfer_kind: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 The block SHALL have port size, input, 3, meaning transfer_size; it is ignored.
REQ-010 The block SHALL have port wdata, input, 32, meaning write data, valid in the data phase.
REQ-011 The block SHALL have port ready_in, input, 1, meaning bus-wide HREADY.
REQ-012 The block SHALL have port rdata, output, 32, meaning read data, valid in the data phase.
REQ-013 The block SHALL have port ready_out, output, 1, meaning slave ready (HREADYOUT).
REQ-014 The block SHALL have port resp, output, 1, meaning transfer_response: OKAY=0, ERROR=1.
REQ-015 The block SHALL have port tx, output, 1, meaning the serial line; idle high.
REQ-016 The block SHALL have port irq, output, 1, meaning a level interrupt, high while the FIFO is empty and the shifter is idle.

Function
REQ-017 An address phase SHALL be accepted when sel=1, trans[1]=1 and ready_in=1.
- On acceptance, addr[3:2] and write are registered.
- The following cycle is the data phase.
REQ-018 The register map SHALL be:
- 0x0 DATA: write-only; wdata[7:0] is pushed to the FIFO; reads return 0.
- 0x4 STATUS: read-only; bit0=shifter busy, bit1=FIFO full, bit2=FIFO empty, bits[8:4]=FIFO count, all other bits 0.
- 0x8 DIVISOR: read/write, 16 bits, bits[31:16] read as 0.
- 0xC: unmapped.
REQ-019 An OKAY data phase SHALL complete in one cycle with ready_out=1 and resp=0 (zero wait states).
REQ-020 An ERROR response SHALL be two cycles:
- cycle 1: ready_out=0, resp=1.
- cycle 2: ready_out=1, resp=1.
REQ-021 An ERROR response SHALL be issued for each of the following, with no state change:
- a write to DATA while the FIFO count equals FIFO_DEPTH at the data-phase cycle, even if a pop occurs in that same cycle;
- a write to STATUS;
- any access to 0xC.
REQ-022 The FIFO SHALL behave as follows:
- Push and pop SHALL be allowed in the same cycle.
- On a simultaneous push and pop, the count SHALL be unchanged.
- Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 The transmitter state machine SHALL have states IDLE, START, DATA and STOP.
- IDLE: tx=1. If the FIFO is not empty, pop one byte into the shift register, load the bit counter with 0, and go to START.
- START: tx=0 for D cycles, then go to DATA.
- DATA: tx=shift[0] for D cycles per bit, LSB first. After 8 bits, go to STOP.
- STOP: tx=1 for D cycles, then go to IDLE.
REQ-024 The bit timing counter SHALL use D = DIVISOR, with DIVISOR=0 treated as 1.
- DIVISOR is sampled when a byte is popped.
- A DIVISOR write during a frame SHALL take effect from the next frame.
REQ-025 A full frame SHALL therefore last 10*D cycles.
- A back-to-back frame SHALL begin 1 cycle after STOP ends, because IDLE lasts one cycle.
REQ-026 Busy (STATUS bit0) SHALL be 1 in the START, DATA and STOP states.
REQ-027 For rdata, ready_out, resp and tx, only the values stated above SHALL appear.
- rdata SHALL be 0 outside a read data phase.

Reset
REQ-028 While nreset=0, the outputs SHALL be tx=1, ready_out=1, resp=0, rdata=0 and irq=1.
REQ-029 While nreset=0, internal state SHALL be: FIFO empty, pointers 0, state IDLE, DIVISOR=DEFAULT_DIVISOR, no pending data phase.
REQ-030 On reset assertion mid-frame, the frame in flight SHALL be aborted.
- tx SHALL go to 1 immediately.
- FIFO contents SHALL be discarded.

Verification
REQ-031 Reset, then read 0x4 and 0x8 -> STATUS=0x00000004 and DIVISOR=16, both OKAY.
REQ-032 Write DIVISOR=4, then write DATA=0xA5:
- tx goes low 2 cycles after the DATA data phase;
- the waveform is 0,1,0,1,0,0,1,0,1,1 with each bit lasting 4 cycles;
- irq rises after the stop bit.
REQ-033 With DIVISOR=1000, write DATA 9 times back-to-back:
- writes 1-9 are OKAY (the first byte is popped into the shifter);
- the 10th write gets a two-cycle ERROR;
- STATUS count reads 8.
REQ-034 Read 0xC and write 0x4 -> both give a two-cycle ERROR, and STATUS/DIVISOR are unchanged.
REQ-035 With DIVISOR=0, write DATA=0xFF -> the frame is 10 cycles long: 1 low start bit, then 9 high cycles.
REQ-036 Drop nreset during the DATA state with 3 bytes queued -> tx=1 at once, and after release STATUS=0x00000004.

Source files
------------

// File: rtl/ahb_uart_tx.sv
// ---------------------------------------------------------------------------
// ahb_uart_tx
//
// This is a transmit-only UART with an AHB-Lite slave port. The bus can:
//   - push bytes into a transmit FIFO,
//   - read the STATUS register,
//   - read and write the 16-bit bit-period DIVISOR register.
// The serial frame is 8N1: one start bit, eight data bits LSB first, and one
// stop bit. Each bit lasts D clocks, where D = DIVISOR. DIVISOR=0 is treated
// as D=1.
//
// Ports
//   clock      : single clock; all state changes on its rising edge
//   nreset     : asynchronous, active-low reset
//   sel        : device select from the bus decoder
//   addr[31:0] : byte address; only bits [3:2] select a register
//   write      : 1 = write, 0 = read
//   trans[1:0] : transfer kind (IDLE/BUSY/NONSEQ/SEQ)
//   size[2:0]  : transfer size; ignored
//   wdata[31:0]: write data, sampled in the data phase
//   ready_in   : bus-wide HREADY
//   rdata[31:0]: read data; zero outside a read data phase
//   ready_out  : HREADYOUT
//   resp       : 0 = OKAY, 1 = ERROR
//   tx         : serial output, idle high
//   irq        : high while the FIFO is empty and the shifter is idle
// ---------------------------------------------------------------------------
module ahb_uart_tx #(
  parameter int FIFO_DEPTH      = 8,
  parameter int DEFAULT_DIVISOR = 16
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [1:0]  trans,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic        ready_in,
  output logic [31:0] rdata,
  output logic        ready_out,
  output logic        resp,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_UNMAP  = 2'd3;

  logic            dp_valid_q, dp_write_q, err2_q;
  logic [1:0]      dp_addr_q;
  logic [15:0]     div_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [15:0]     baud_q, baud_d, dlat_q, dlat_d;

  logic addr_acc, count_full, dp_err, push, pop, div_we, baud_end;
  logic unused_ok;

  assign unused_ok = ^{size, addr[31:4], addr[1:0], trans[0], wdata[31:16]};

  assign addr_acc   = sel & trans[1] & ready_in;
  assign count_full = (count_q == FULL_CNT);

  // The full check uses the count at the data-phase cycle. A pop in the same
  // cycle does not rescue the write.
  assign dp_err = dp_valid_q & ((dp_addr_q == A_UNMAP) |
                                (dp_write_q & (dp_addr_q == A_STATUS)) |
                                (dp_write_q & (dp_addr_q == A_DATA) & count_full));
  assign push   = dp_valid_q & dp_write_q & (dp_addr_q == A_DATA) & ~count_full;
  assign div_we = dp_valid_q & dp_write_q & (dp_addr_q == A_DIV);
  assign pop    = (state_q == ST_IDLE) & (count_q != '0);

  // An ERROR is two cycles: the first cycle is the data phase itself with
  // ready_out low; err2_q then supplies the closing cycle with ready_out high.
  assign ready_out = ~dp_err;
  assign resp      = dp_err | err2_q;

  always_comb begin
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        A_STATUS: rdata = {23'd0, 5'(count_q), 1'b0, (count_q == '0), count_full,
                           (state_q != ST_IDLE)};
        A_DIV:    rdata = {16'd0, div_q};
        default:  rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      err2_q     <= 1'b0;
      div_q      <= 16'(DEFAULT_DIVISOR);
    end else begin
      dp_valid_q <= addr_acc;
      if (addr_acc) begin
        dp_write_q <= write;
        dp_addr_q  <= addr[3:2];
      end
      err2_q <= dp_err;
      if (div_we) div_q <= wdata[15:0];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  // The bit period is latched at pop time. A DIVISOR write therefore only
  // affects frames that have not started yet.
  assign baud_end = (baud_q == dlat_q - 16'd1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    dlat_d  = dlat_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_START;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = 3'd0;
          baud_d  = 16'd0;
          dlat_d  = (div_q == 16'd0) ? 16'd1 : div_q;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      dlat_q  <= 16'd1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      dlat_q  <= dlat_d;
    end
  end

  // tx is decoded from the state, so a reset forces it high immediately.
  assign tx  = (state_q == ST_START) ? 1'b0 :
               (state_q == ST_DATA)  ? shift_q[0] : 1'b1;
  assign irq = (count_q == '0) & (state_q == ST_IDLE);

endmodule

// File: tb/tb_ahb_uart_tx.sv
module tb_ahb_uart_tx;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        nreset, sel, write, ready_in;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  trans;
  logic [2:0]  size;
  logic        ready_out, resp, tx, irq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic tx_log  [65536];
  logic irq_log [65536];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    tx_log[cyc % 65536]  <= tx;
    irq_log[cyc % 65536] <= irq;
  end

  // Single-slave bus: HREADY is this slave's own HREADYOUT.
  assign ready_in = ready_out;

  ahb_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(16)) dut (
    .clock(clock), .nreset(nreset), .sel(sel), .addr(addr), .write(write),
    .trans(trans), .size(size), .wdata(wdata), .ready_in(ready_in),
    .rdata(rdata), .ready_out(ready_out), .resp(resp), .tx(tx), .irq(irq)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input bit busy, input int cnt);
    return 32'((busy ? 1 : 0) + ((cnt == DEPTH) ? 2 : 0) + ((cnt == 0) ? 4 : 0) + cnt * 16);
  endfunction

  // One bus transfer. dpc returns the cycle index of the data phase.
  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic exp_err,
                      output logic [31:0] rd, output int dpc);
    @(negedge clock);
    sel = 1'b1; addr = a; write = w; trans = 2'b10; size = 3'b010;
    @(negedge clock);
    sel = 1'b0; trans = 2'b00; addr = '0; write = 1'b0; wdata = wd;
    dpc = cyc;
    rd  = rdata;
    chk({tag, ".ready1"}, 32'(ready_out), 32'(!exp_err));
    chk({tag, ".resp1"},  32'(resp),      32'(exp_err));
    if (w) chk({tag, ".rdata_wr"}, rdata, 32'd0);
    if (exp_err) begin
      @(negedge clock);
      chk({tag, ".ready2"}, 32'(ready_out), 32'd1);
      chk({tag, ".resp2"},  32'(resp),      32'd1);
    end
    @(posedge clock);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int d;
    xfer(tag, a, 1'b0, 32'd0, 1'b0, r, d);
    chk({tag, ".rdata"}, r, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] v,
                    input logic exp_err, output int dpc);
    logic [31:0] r;
    xfer(tag, a, 1'b1, v, exp_err, r, dpc);
  endtask

  // Expected line waveform for a burst of frames, the first starting at
  // cycle 'start': per frame D low, 8 data bits LSB first of D each, D high,
  // and one idle cycle between consecutive frames.
  task automatic check_stream(input string tag, input int start,
                              input bit [7:0] bytes[$], input int ds[$]);
    bit q[$];
    int len;
    for (int i = 0; i < bytes.size(); i++) begin
      int d;
      bit [7:0] v;
      d = (ds[i] == 0) ? 1 : ds[i];
      v = bytes[i];
      if (i > 0) q.push_back(1'b1);
      for (int c = 0; c < d; c++) q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < d; c++) q.push_back(v[b]);
      for (int c = 0; c < d; c++) q.push_back(1'b1);
    end
    len = q.size();
    while (cyc < start + len + 2) @(negedge clock);
    chk($sformatf("%s.pre_tx", tag),  32'(tx_log[(start - 1) % 65536]), 32'd1);
    chk($sformatf("%s.pre_irq", tag), 32'(irq_log[(start - 1) % 65536]), 32'd0);
    for (int j = 0; j < len; j++) begin
      chk($sformatf("%s.tx[%0d]", tag, j),  32'(tx_log[(start + j) % 65536]), 32'(q[j]));
      chk($sformatf("%s.irq[%0d]", tag, j), 32'(irq_log[(start + j) % 65536]), 32'd0);
    end
    chk($sformatf("%s.post_tx", tag),  32'(tx_log[(start + len) % 65536]), 32'd1);
    chk($sformatf("%s.post_irq", tag), 32'(irq_log[(start + len) % 65536]), 32'd1);
  endtask

  initial begin
    int dpc, first;
    bit [7:0] bq[$];
    int dq[$];
    logic [31:0] r, tmp;

    nreset = 1'b0; sel = 1'b0; addr = '0; write = 1'b0; trans = 2'b00;
    size = 3'b000; wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst.tx", 32'(tx), 32'd1);
    chk("rst.ready", 32'(ready_out), 32'd1);
    chk("rst.resp", 32'(resp), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.irq", 32'(irq), 32'd1);
    nreset = 1'b1;

    rd_chk("status0", 32'h4, 32'h0000_0004);
    rd_chk("div0",    32'h8, 32'd16);

    // 0xA5 at D=4
    wr("div4", 32'h8, 32'd4, 1'b0, dpc);
    wr("a5", 32'h0, 32'h0000_00A5, 1'b0, dpc);
    bq = '{8'hA5}; dq = '{4};
    check_stream("a5", dpc + 2, bq, dq);

    // D=0 behaves as D=1
    wr("div0w", 32'h8, 32'd0, 1'b0, dpc);
    wr("ff", 32'h0, 32'h0000_00FF, 1'b0, dpc);
    bq = '{8'hFF}; dq = '{0};
    check_stream("ff", dpc + 2, bq, dq);

    // DIVISOR rewritten mid-frame applies to the following frame only
    wr("div3", 32'h8, 32'd3, 1'b0, first);
    wr("m1", 32'h0, 32'h0000_0036, 1'b0, first);
    wr("div2", 32'h8, 32'd2, 1'b0, dpc);
    wr("m2", 32'h0, 32'h0000_00C9, 1'b0, dpc);
    bq = '{8'h36, 8'hC9}; dq = '{3, 2};
    check_stream("mid", first + 2, bq, dq);

    // randomized bursts
    for (int it = 0; it < 6; it++) begin
      int d, n;
      d = $urandom_range(1, 6);
      n = $urandom_range(1, 4);
      tmp = $urandom();
      wr($sformatf("r%0d.div", it), 32'h8, {tmp[31:16], 16'(d)}, 1'b0, dpc);
      rd_chk($sformatf("r%0d.divrd", it), 32'h8, 32'(d));
      bq = {}; dq = {};
      for (int i = 0; i < n; i++) begin
        bit [7:0] b;
        tmp = $urandom();
        b = tmp[7:0];
        wr($sformatf("r%0d.w%0d", it, i), 32'h0, tmp, 1'b0, dpc);
        if (i == 0) first = dpc;
        bq.push_back(b);
        dq.push_back(d);
      end
      check_stream($sformatf("r%0d", it), first + 2, bq, dq);
      rd_chk($sformatf("r%0d.status", it), 32'h4, status_word(1'b0, 0));
    end

    // fill the FIFO while a slow frame holds the shifter
    wr("div1000", 32'h8, 32'd1000, 1'b0, dpc);
    for (int i = 0; i < 9; i++) begin
      wr($sformatf("fill%0d", i), 32'h0, 32'h0000_0040 + 32'(i), 1'b0, dpc);
      if (i == 0) first = dpc;
    end
    wr("overflow", 32'h0, 32'h0000_0077, 1'b1, dpc);
    rd_chk("status_full", 32'h4, status_word(1'b1, 8));

    // unmapped and read-only accesses
    xfer("rd_c", 32'hC, 1'b0, 32'd0, 1'b1, r, dpc);
    tmp = $urandom();
    wr("wr_status", 32'h4, tmp, 1'b1, dpc);
    rd_chk("status_after_err", 32'h4, status_word(1'b1, 8));
    rd_chk("div_after_err", 32'h8, 32'd1000);

    // reset while shifting bit 1 of 0x40 (a 0 bit)
    while (cyc < first + 2 + 1000 + 1500) @(negedge clock);
    chk("pre_reset_tx", 32'(tx), 32'd0);
    @(posedge clock);
    #2 nreset = 1'b0;
    #1;
    chk("midrst.tx", 32'(tx), 32'd1);
    chk("midrst.irq", 32'(irq), 32'd1);
    chk("midrst.ready", 32'(ready_out), 32'd1);
    chk("midrst.resp", 32'(resp), 32'd0);
    chk("midrst.rdata", rdata, 32'd0);
    @(negedge clock);
    nreset = 1'b1;
    repeat (5) @(negedge clock);
    chk("postrst.tx", 32'(tx), 32'd1);
    chk("postrst.irq", 32'(irq), 32'd1);
    rd_chk("postrst.status", 32'h4, 32'h0000_0004);
    rd_chk("postrst.div", 32'h8, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
